// File: rtl/fround.sv
// Two-stage pipelined rounding of an IEEE-754 single to an integral-valued single.
// Stage 1 decodes and resolves special cases; stage 2 adds the increment and renormalises.
module fround (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic [1:0]  mode,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [1:0] MODE_RNE   = 2'b00;
  localparam logic [1:0] MODE_TRUNC = 2'b01;
  localparam logic [1:0] MODE_FLOOR = 2'b10;
  localparam logic [1:0] MODE_CEIL  = 2'b11;

  logic        v1_q, v2_q;
  logic        s1_q, s1_d;
  logic [7:0]  e1_q, e1_d;
  logic [23:0] base1_q, base1_d;
  logic [23:0] inc1_q, inc1_d;
  logic        byp1_q, byp1_d;
  logic [31:0] bypv1_q, bypv1_d;
  logic [31:0] y_q, y_d;

  logic        sgn;
  logic [7:0]  ex;
  logic [23:0] sig;
  logic [4:0]  fsh;
  logic [23:0] mask;
  logic        intLsb, rbit, sticky, fracNz, inc;
  logic [24:0] sum;
  logic        ld1, ld2;

  assign ld2      = v1_q & (~v2_q | out_ready);
  assign in_ready = ~v1_q | ~v2_q | out_ready;
  assign ld1      = in_valid & in_ready;

  // Fraction-bit count 150-e reduced mod 32; only meaningful for 127 <= e <= 149.
  always_comb begin
    sgn    = x[31];
    ex     = x[30:23];
    sig    = {1'b1, x[22:0]};
    fsh    = 5'd22 - ex[4:0];
    mask   = (24'd1 << fsh) - 24'd1;
    intLsb = sig[fsh];
    rbit   = sig[fsh - 5'd1];
    sticky = |(sig & (mask >> 1));
    fracNz = rbit | sticky;
    case (mode)
      MODE_RNE:   inc = rbit & (sticky | intLsb);
      MODE_TRUNC: inc = 1'b0;
      MODE_FLOOR: inc = sgn & fracNz;
      default:    inc = ~sgn & fracNz;
    endcase
    s1_d    = sgn;
    e1_d    = ex;
    base1_d = sig & ~mask;
    inc1_d  = inc ? (24'd1 << fsh) : 24'd0;
    byp1_d  = 1'b1;
    bypv1_d = x;
    if (ex == 8'd0) begin
      bypv1_d = {sgn, 31'b0};
    end else if (ex >= 8'd150) begin
      bypv1_d = x;
    end else if (ex <= 8'd126) begin
      // Magnitude below one: result is a signed zero or a signed one.
      case (mode)
        MODE_RNE:   bypv1_d = (ex == 8'd126 && x[22:0] != 23'd0) ? {sgn, 31'h3F800000} : {sgn, 31'b0};
        MODE_TRUNC: bypv1_d = {sgn, 31'b0};
        MODE_FLOOR: bypv1_d = sgn ? 32'hBF800000 : 32'h00000000;
        MODE_CEIL:  bypv1_d = sgn ? 32'h80000000 : 32'h3F800000;
        default:    bypv1_d = {sgn, 31'b0};
      endcase
    end else begin
      byp1_d = 1'b0;
    end
  end

  // A carry out of bit 23 means sum is exactly 2^24, so shifting right leaves a zero mantissa.
  always_comb begin
    sum = {1'b0, base1_q} + {1'b0, inc1_q};
    if (byp1_q) begin
      y_d = bypv1_q;
    end else begin
      y_d = {s1_q, e1_q + {7'd0, sum[24]}, sum[24] ? sum[23:1] : sum[22:0]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q    <= 1'b0;
      s1_q    <= 1'b0;
      e1_q    <= 8'd0;
      base1_q <= 24'd0;
      inc1_q  <= 24'd0;
      byp1_q  <= 1'b0;
      bypv1_q <= 32'd0;
    end else begin
      if (ld1) begin
        v1_q    <= 1'b1;
        s1_q    <= s1_d;
        e1_q    <= e1_d;
        base1_q <= base1_d;
        inc1_q  <= inc1_d;
        byp1_q  <= byp1_d;
        bypv1_q <= bypv1_d;
      end else if (ld2) begin
        v1_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_q <= 1'b0;
      y_q  <= 32'd0;
    end else begin
      if (ld2) begin
        v2_q <= 1'b1;
        y_q  <= y_d;
      end else if (out_ready) begin
        v2_q <= 1'b0;
      end
    end
  end

  assign y         = y_q;
  assign out_valid = v2_q;

endmodule

// File: tb/tb_fround.sv
// Self-checking bench for fround: directed corner cases, backpressure, reset and random traffic
// compared against an integer-arithmetic rounding model.
module tb_fround;

  logic        clk;
  logic        rstn;
  logic [31:0] x;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;

  int          checks;
  int          errors;
  int          drained;
  logic [31:0] expQ[$];
  logic        holdPending;
  logic [31:0] heldY;

  fround dut (
    .clk(clk),
    .rstn(rstn),
    .x(x),
    .mode(mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y(y),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rounds by treating the operand as integer part q plus remainder, then re-encodes q.
  function automatic logic [31:0] roundRef(input logic [31:0] xv, input logic [1:0] md);
    logic   s;
    int     e, f, cmp, p;
    longint sig, q, r, half, mant;
    bit     nz, up;
    s   = xv[31];
    e   = int'(xv[30:23]);
    sig = longint'({1'b1, xv[22:0]});
    if (e == 0) return {s, 31'b0};
    if (e >= 150) return xv;
    if (e >= 127) begin
      f    = 150 - e;
      q    = sig >> f;
      r    = sig - (q << f);
      half = longint'(1) << (f - 1);
      cmp  = (r > half) ? 1 : ((r == half) ? 0 : -1);
      nz   = (r != 0);
    end else begin
      q   = 0;
      nz  = 1'b1;
      cmp = (e == 126) ? ((xv[22:0] != 23'd0) ? 1 : 0) : -1;
    end
    case (md)
      2'b00:   up = (cmp > 0) || (cmp == 0 && (q % 2) == 1);
      2'b01:   up = 1'b0;
      2'b10:   up = s && nz;
      default: up = !s && nz;
    endcase
    q = q + (up ? 1 : 0);
    if (q == 0) return {s, 31'b0};
    p = 0;
    while ((q >> (p + 1)) != 0) p++;
    mant = (p <= 23) ? (q << (23 - p)) : (q >> (p - 23));
    return {s, 8'(127 + p), mant[22:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, sample just after they settle, then advance past the next edge.
  task automatic applyStimulus(input logic vin, input logic [31:0] xin, input logic [1:0] md,
                               input logic ordy, input logic [31:0] exp, output logic accepted);
    in_valid  = vin;
    x         = xin;
    mode      = md;
    out_ready = ordy;
    #1;
    if (holdPending) begin
      checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_y", y, heldY);
    end
    holdPending = out_valid & ~out_ready;
    heldY       = y;
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out", y, 32'hDEADBEEF);
      end else begin
        checkOutput("y", y, expQ.pop_front());
        drained++;
      end
    end
    accepted = vin && in_ready;
    if (accepted) expQ.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic sendOne(input logic [31:0] xin, input logic [1:0] md, input logic [31:0] exp);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) applyStimulus(1'b1, xin, md, 1'b1, exp, acc);
    if (!acc) checkOutput("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drainAll();
    logic acc;
    for (int i = 0; i < 60 && expQ.size() != 0; i++) applyStimulus(1'b0, 32'd0, 2'b00, 1'b1, 32'd0, acc);
    checkOutput("drain_left", expQ.size(), 32'd0);
  endtask

  task automatic checkLatency(input logic [31:0] xin, input logic [1:0] md, input logic [31:0] exp);
    in_valid  = 1'b1;
    x         = xin;
    mode      = md;
    out_ready = 1'b1;
    #1;
    checkOutput("lat_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("lat_cycle2_y", y, exp);
    @(posedge clk);
    #1;
    checkOutput("lat_after_valid", {31'd0, out_valid}, 32'd0);
  endtask

  logic [31:0] bp[4];
  logic [31:0] rx;
  logic [1:0]  rm;
  logic [7:0]  re;
  logic        acc;
  int          idx;
  int          base;

  initial begin
    checks      = 0;
    errors      = 0;
    drained     = 0;
    holdPending = 1'b0;
    heldY       = 32'd0;
    rstn        = 1'b1;
    in_valid    = 1'b0;
    x           = 32'd0;
    mode        = 2'b00;
    out_ready   = 1'b1;

    #3 rstn = 1'b0;
    #1;
    checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_y", y, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    checkLatency(32'h40200000, 2'b00, 32'h40000000);

    sendOne(32'h40200000, 2'b00, 32'h40000000);
    sendOne(32'h40600000, 2'b00, 32'h40800000);
    sendOne(32'h4AFFFFFF, 2'b00, 32'h4B000000);
    sendOne(32'h3F800001, 2'b11, 32'h40000000);
    sendOne(32'hBE800000, 2'b10, 32'hBF800000);
    sendOne(32'hBE800000, 2'b11, 32'h80000000);
    sendOne(32'h3F000000, 2'b00, 32'h00000000);
    sendOne(32'h80000001, 2'b10, 32'h80000000);
    for (int m = 0; m < 4; m++) begin
      sendOne(32'h7FC00000, 2'(m), 32'h7FC00000);
      sendOne(32'h4B800001, 2'(m), 32'h4B800001);
    end
    drainAll();

    // Four back-to-back inputs against a stalled output.
    bp[0] = 32'h40200000;
    bp[1] = 32'h3FC00000;
    bp[2] = 32'hC0600000;
    bp[3] = 32'h41234567;
    base  = drained;
    idx   = 0;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, bp[idx], 2'b00, 1'b0, roundRef(bp[idx], 2'b00), acc);
      if (acc) idx++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    #1;
    checkOutput("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_idx", idx, 32'd2);
    applyStimulus(1'b1, bp[idx], 2'b00, 1'b0, roundRef(bp[idx], 2'b00), acc);
    if (acc) idx++;
    for (int c = 0; c < 30 && (idx < 4 || expQ.size() != 0); c++) begin
      applyStimulus(idx < 4, bp[idx % 4], 2'b00, 1'b1, roundRef(bp[idx % 4], 2'b00), acc);
      if (acc) idx++;
    end
    checkOutput("bp_drained", drained - base, 32'd4);

    // Fill both stages, then pull reset mid-cycle.
    sendOne(32'h40600000, 2'b00, 32'h40800000);
    applyStimulus(1'b1, 32'h3F800001, 2'b11, 1'b0, 32'h40000000, acc);
    applyStimulus(1'b0, 32'd0, 2'b00, 1'b0, 32'd0, acc);
    #2 rstn = 1'b0;
    #1;
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_y", y, 32'd0);
    expQ.delete();
    holdPending = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checkLatency(32'h40600000, 2'b00, 32'h40800000);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 9))
        0:       re = 8'd0;
        1:       re = 8'($urandom);
        default: re = 8'($urandom_range(120, 152));
      endcase
      rx = {1'($urandom), re, 23'($urandom)};
      rm = 2'($urandom);
      applyStimulus(1'($urandom_range(0, 3) != 0), rx, rm, 1'($urandom_range(0, 3) != 0), roundRef(rx, rm), acc);
    end
    drainAll();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
